perceptron_trainer: RTL and testbench
=====================================

Name: perceptron_trainer

Overview:
- Parametrised successor to the neuron training controller. Trains a single perceptron with N_INPUTS weights plus a bias using the perceptron rule.
- Controller and datapath are integrated: MAC, compare, weight update, and sample/epoch counting.
- Sits between a sample source (valid/ready stream) and the neuron inference path, which reads the weights/bias outputs.

Parameters:
- N_INPUTS, 2, number of inputs/weights (>=1)
- X_W, 8, signed input width
- W_W, 16, signed weight/bias width
- NUM_SAMPLES, 4, samples per epoch (>=1)
- MAX_EPOCHS, 16, epoch limit (>=1)
- LR_SHIFT, 0, learning rate = 2^-LR_SHIFT (arithmetic right shift of delta)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin training; sampled in IDLE/DONE only
- sample_valid  in  1  sample present
- sample_ready  out  1  trainer accepts sample
- sample_x  in  N_INPUTS*X_W  signed inputs, x[i] at bits [i*X_W +: X_W]
- sample_t  in  1  target: 1 = +1, 0 = -1
- weights  out  N_INPUTS*W_W  signed weights, same packing
- bias  out  W_W  signed bias
- busy  out  1  high in any state except IDLE/DONE
- done  out  1  high in DONE
- converged  out  1  valid when done; 1 = zero-error epoch reached
- epoch_cnt  out  $clog2(MAX_EPOCHS+1)  index of current/last epoch
- err_cnt  out  $clog2(NUM_SAMPLES+1)  errors in current/last epoch

Behaviour:
- Reset (rst=0, async): state IDLE; weights, bias, counters, converged, done, busy, and sample_ready all 0.
- States: IDLE, INIT, FETCH, COMPUTE, DECIDE, UPDATE, CHECK, DONE.
- IDLE/DONE: start=1 -> INIT.
- INIT (1 cycle): weights, bias, epoch_cnt, err_cnt, sample index, and converged cleared -> FETCH.
- FETCH: sample_ready=1. On sample_valid & sample_ready, latch x and t, set acc = sign-extended bias -> COMPUTE. Valid low stalls indefinitely.
- COMPUTE (N_INPUTS cycles): acc += w[i]*x[i], i = 0..N-1. acc width W_W+X_W+$clog2(N_INPUTS+1), no overflow.
- DECIDE (1 cycle): y = +1 if acc >= 0, else -1.
  - y == t -> CHECK-path (index advance).
  - y != t -> err_cnt++, UPDATE.
- UPDATE (N_INPUTS+1 cycles):
  - w[i] += (t ? x[i] : -x[i]) >>> LR_SHIFT. Delta is formed at W_W+1 bits, so -(-2^(X_W-1)) is exact.
  - Last cycle: bias += (t ? +1 : -1).
  - Results wrap modulo 2^W_W (see SAT_EN).
- Sample index advance:
  - If index < NUM_SAMPLES-1: index++ -> FETCH.
  - Otherwise -> CHECK.
- CHECK (1 cycle):
  - err_cnt == 0 -> DONE, converged=1.
  - Else if epoch_cnt == MAX_EPOCHS-1 -> DONE, converged=0.
  - Else epoch_cnt++, err_cnt=0, index=0 -> FETCH.
- DONE: done=1; weights, bias, and counters held until start.
- Latency: sample_ready reasserts N_INPUTS+2 cycles after acceptance if correct, 2*N_INPUTS+3 if an update occurs (+1 at epoch end for CHECK).
- start outside IDLE/DONE is ignored.
- Reset mid-operation aborts immediately; all state returns to reset values.

Optional Feature:
- Macro PERCEPTRON_SAT_EN.
- Defined: each weight/bias update saturates to [-2^(W_W-1), 2^(W_W-1)-1].
- Undefined: two's-complement wrap.

Test Plan:
- AND, N=2, LR_SHIFT=0. Samples per epoch (-1,-1,t0), (-1,+1,t0), (+1,-1,t0), (+1,+1,t1) -> done with converged=1, epoch_cnt=1, weights=(1,1), bias=-1; err_cnt=1 during epoch 0, err_cnt=0 at end.
- XOR (±1 encoding), MAX_EPOCHS=8 -> done with converged=0, epoch_cnt=7, err_cnt>0.
- Backpressure: sample_valid held low 20 cycles in FETCH -> state, weights, and counters unchanged; sample_ready stays 1; training resumes correctly.
- N=1, X_W=8, W_W=8, NUM_SAMPLES=1, x=-128, t=-1:
  - With PERCEPTRON_SAT_EN: first update gives w=127, bias=-1.
  - Without: w=-128.
- rst pulsed low during UPDATE -> all outputs 0 asynchronously. Then start -> AND scenario repeats with identical results.
- Restart from DONE: after AND converges, start=1 -> INIT clears weights to 0, and identical training reproduces the same final values.

Source files
------------

// File: rtl/perceptron_trainer.sv
// perceptron_trainer
// Trains one perceptron (N_INPUTS weights plus a bias) with the perceptron rule.
// Samples arrive on a valid/ready stream. The trained weights and bias are
// exposed continuously so the inference path can read them.
//
// Ports:
//   clk, rst         rising-edge clock; asynchronous active-low reset
//   start            begin (or restart) training; honoured only in IDLE/DONE
//   sample_valid/_ready, sample_x, sample_t
//                    sample stream; x[i] = sample_x[i*X_W +: X_W], t: 1=+1, 0=-1
//   weights, bias    signed trained values, w[i] = weights[i*W_W +: W_W]
//   busy, done       status; converged is meaningful while done=1
//   epoch_cnt        current/last epoch index
//   err_cnt          misclassifications in the current/last epoch
//
// Build option: define PERCEPTRON_SAT_EN to saturate weight/bias updates
// instead of letting them wrap in two's complement.
module perceptron_trainer #(
  parameter int N_INPUTS    = 2,
  parameter int X_W         = 8,
  parameter int W_W         = 16,
  parameter int NUM_SAMPLES = 4,
  parameter int MAX_EPOCHS  = 16,
  parameter int LR_SHIFT    = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               sample_valid,
  output logic                               sample_ready,
  input  logic [N_INPUTS*X_W-1:0]            sample_x,
  input  logic                               sample_t,
  output logic [N_INPUTS*W_W-1:0]            weights,
  output logic [W_W-1:0]                     bias,
  output logic                               busy,
  output logic                               done,
  output logic                               converged,
  output logic [$clog2(MAX_EPOCHS+1)-1:0]    epoch_cnt,
  output logic [$clog2(NUM_SAMPLES+1)-1:0]   err_cnt
);

  localparam int ACC_W = W_W + X_W + $clog2(N_INPUTS + 1);
  localparam int CW    = $clog2(N_INPUTS + 1);   // step counter, 0..N_INPUTS
  localparam int IW    = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam int EW    = $clog2(MAX_EPOCHS + 1);
  localparam int RW    = $clog2(NUM_SAMPLES + 1);
  localparam int DW    = W_W + 1;                // delta width: negating -2^(X_W-1) stays exact
  localparam int SW    = W_W + 2;                // update sum width, wide enough to detect overflow

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_FETCH, S_COMPUTE, S_DECIDE, S_UPDATE, S_CHECK, S_DONE
  } state_t;

  state_t                    state_reg, state_next;
  logic [CW-1:0]             step_reg, step_next;
  logic [IW-1:0]             idx_reg, idx_next;
  logic [EW-1:0]             epoch_reg, epoch_next;
  logic [RW-1:0]             err_reg, err_next;
  logic                      conv_reg, conv_next;
  logic signed [ACC_W-1:0]   acc_reg, acc_next;
  logic [N_INPUTS*X_W-1:0]   x_reg, x_next;
  logic                      t_reg, t_next;
  logic [W_W-1:0]            bias_reg, bias_next;

  // Shared datapath: one multiplier for the MAC and one adder for all updates.
  logic [CW-1:0]             rd_idx;
  logic [W_W-1:0]            w_cur;
  logic [X_W-1:0]            x_cur;
  logic signed [ACC_W-1:0]   w_ext, x_ext, prod;
  logic signed [DW-1:0]      x_d, delta_raw, delta_sh, upd_delta;
  logic [W_W-1:0]            upd_base, upd_res;
  logic [SW-1:0]             upd_sum;
  logic                      last_step, y_pos, advance;

  // During the bias step (step == N_INPUTS) the weight read is a don't-care; park it on w[0].
  assign rd_idx = (step_reg < CW'(N_INPUTS)) ? step_reg : '0;
  assign w_cur  = weights[rd_idx*W_W +: W_W];
  assign x_cur  = x_reg[rd_idx*X_W +: X_W];

  always_comb begin
    w_ext     = {{(ACC_W-W_W){w_cur[W_W-1]}}, w_cur};
    x_ext     = {{(ACC_W-X_W){x_cur[X_W-1]}}, x_cur};
    prod      = w_ext * x_ext;
    x_d       = {{(DW-X_W){x_cur[X_W-1]}}, x_cur};
    delta_raw = t_reg ? x_d : -x_d;
    delta_sh  = delta_raw >>> LR_SHIFT;
    last_step = (step_reg == CW'(N_INPUTS));
    upd_base  = last_step ? bias_reg : w_cur;
    upd_delta = last_step ? (t_reg ? DW'(1) : {DW{1'b1}}) : delta_sh;
    upd_sum   = {{2{upd_base[W_W-1]}}, upd_base} + {upd_delta[DW-1], upd_delta};
`ifdef PERCEPTRON_SAT_EN
    // In range only when the three top bits agree; otherwise clamp by sign.
    if ((upd_sum[SW-1:W_W-1] == 3'b000) || (upd_sum[SW-1:W_W-1] == 3'b111))
      upd_res = upd_sum[W_W-1:0];
    else if (upd_sum[SW-1])
      upd_res = {1'b1, {(W_W-1){1'b0}}};
    else
      upd_res = {1'b0, {(W_W-1){1'b1}}};
`else
    upd_res = upd_sum[W_W-1:0];
`endif
    y_pos = ~acc_reg[ACC_W-1];
  end

`ifndef PERCEPTRON_SAT_EN
  // The wrap discards the overflow bits of the sum.
  logic wrap_unused;
  assign wrap_unused = &{1'b0, upd_sum[SW-1:W_W]};
`endif

  // Next-state and datapath control.
  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    idx_next   = idx_reg;
    epoch_next = epoch_reg;
    err_next   = err_reg;
    conv_next  = conv_reg;
    acc_next   = acc_reg;
    x_next     = x_reg;
    t_next     = t_reg;
    bias_next  = bias_reg;
    advance    = 1'b0;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) state_next = S_INIT;
      end
      S_INIT: begin
        step_next  = '0;
        idx_next   = '0;
        epoch_next = '0;
        err_next   = '0;
        conv_next  = 1'b0;
        bias_next  = '0;
        state_next = S_FETCH;
      end
      S_FETCH: begin
        if (sample_valid) begin
          x_next     = sample_x;
          t_next     = sample_t;
          acc_next   = {{(ACC_W-W_W){bias_reg[W_W-1]}}, bias_reg};
          step_next  = '0;
          state_next = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        acc_next = acc_reg + prod;
        if (step_reg == CW'(N_INPUTS - 1)) begin
          step_next  = '0;
          state_next = S_DECIDE;
        end else begin
          step_next = step_reg + CW'(1);
        end
      end
      S_DECIDE: begin
        if (y_pos == t_reg) begin
          advance = 1'b1;
        end else begin
          err_next   = err_reg + RW'(1);
          step_next  = '0;
          state_next = S_UPDATE;
        end
      end
      S_UPDATE: begin
        // Steps 0..N_INPUTS-1 write the weights (in the generate below); the last step writes the bias.
        if (last_step) begin
          bias_next = upd_res;
          advance   = 1'b1;
        end else begin
          step_next = step_reg + CW'(1);
        end
      end
      S_CHECK: begin
        if (err_reg == '0) begin
          conv_next  = 1'b1;
          state_next = S_DONE;
        end else if (epoch_reg == EW'(MAX_EPOCHS - 1)) begin
          conv_next  = 1'b0;
          state_next = S_DONE;
        end else begin
          epoch_next = epoch_reg + EW'(1);
          err_next   = '0;
          idx_next   = '0;
          state_next = S_FETCH;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (advance) begin
      step_next = '0;
      if (idx_reg < IW'(NUM_SAMPLES - 1)) begin
        idx_next   = idx_reg + IW'(1);
        state_next = S_FETCH;
      end else begin
        state_next = S_CHECK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      step_reg  <= '0;
      idx_reg   <= '0;
      epoch_reg <= '0;
      err_reg   <= '0;
      conv_reg  <= 1'b0;
      acc_reg   <= '0;
      x_reg     <= '0;
      t_reg     <= 1'b0;
      bias_reg  <= '0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      idx_reg   <= idx_next;
      epoch_reg <= epoch_next;
      err_reg   <= err_next;
      conv_reg  <= conv_next;
      acc_reg   <= acc_next;
      x_reg     <= x_next;
      t_reg     <= t_next;
      bias_reg  <= bias_next;
    end
  end

  // One register per weight, written when the update step points at it.
  generate
    for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_weight
      logic [W_W-1:0] w_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          w_reg <= '0;
        else if (state_reg == S_INIT)
          w_reg <= '0;
        else if ((state_reg == S_UPDATE) && (step_reg == CW'(gi)))
          w_reg <= upd_res;
      end
      assign weights[gi*W_W +: W_W] = w_reg;
    end
  endgenerate

  assign bias         = bias_reg;
  assign sample_ready = (state_reg == S_FETCH);
  assign busy         = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign done         = (state_reg == S_DONE);
  assign converged    = conv_reg;
  assign epoch_cnt    = epoch_reg;
  assign err_cnt      = err_reg;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench for perceptron_trainer: AND (converges), XOR (hits the epoch
// limit), backpressure, asynchronous reset mid-update, restart from DONE, and
// a single-weight overflow case whose result depends on PERCEPTRON_SAT_EN.
module tb_perceptron_trainer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instances A (AND, 16 epochs) and B (XOR, 8 epochs) share the sample bus.
  logic        rst_a = 1'b1, rst_b = 1'b1, a_start = 1'b0, b_start = 1'b0;
  logic        sample_valid = 1'b0, sample_t = 1'b0;
  logic [15:0] sample_x = '0;
  logic        a_ready, a_busy, a_done, a_conv, b_ready, b_busy, b_done, b_conv;
  logic [31:0] a_weights, b_weights;
  logic [15:0] a_bias, b_bias;
  logic [4:0]  a_epoch;
  logic [3:0]  b_epoch;
  logic [2:0]  a_err, b_err;

  // Instance C: one 8-bit weight, one sample per epoch.
  logic        rst_c = 1'b1, c_start = 1'b0, c_valid = 1'b0, c_t = 1'b0;
  logic [7:0]  c_x = '0;
  logic        c_ready, c_busy, c_done, c_conv;
  logic [7:0]  c_weights, c_bias;
  logic [4:0]  c_epoch;
  logic [0:0]  c_err;

  perceptron_trainer #(.N_INPUTS(2), .X_W(8), .W_W(16), .NUM_SAMPLES(4), .MAX_EPOCHS(16), .LR_SHIFT(0)) dut_a (
    .clk(clk), .rst(rst_a), .start(a_start), .sample_valid(sample_valid), .sample_ready(a_ready),
    .sample_x(sample_x), .sample_t(sample_t), .weights(a_weights), .bias(a_bias), .busy(a_busy),
    .done(a_done), .converged(a_conv), .epoch_cnt(a_epoch), .err_cnt(a_err));

  perceptron_trainer #(.N_INPUTS(2), .X_W(8), .W_W(16), .NUM_SAMPLES(4), .MAX_EPOCHS(8), .LR_SHIFT(0)) dut_b (
    .clk(clk), .rst(rst_b), .start(b_start), .sample_valid(sample_valid), .sample_ready(b_ready),
    .sample_x(sample_x), .sample_t(sample_t), .weights(b_weights), .bias(b_bias), .busy(b_busy),
    .done(b_done), .converged(b_conv), .epoch_cnt(b_epoch), .err_cnt(b_err));

  perceptron_trainer #(.N_INPUTS(1), .X_W(8), .W_W(8), .NUM_SAMPLES(1), .MAX_EPOCHS(16), .LR_SHIFT(0)) dut_c (
    .clk(clk), .rst(rst_c), .start(c_start), .sample_valid(c_valid), .sample_ready(c_ready),
    .sample_x(c_x), .sample_t(c_t), .weights(c_weights), .bias(c_bias), .busy(c_busy),
    .done(c_done), .converged(c_conv), .epoch_cnt(c_epoch), .err_cnt(c_err));

  // +/-1 sample inputs; targets are given per run as a 4-bit vector.
  logic [7:0] tx0 [4] = '{8'hFF, 8'hFF, 8'h01, 8'h01};
  logic [7:0] tx1 [4] = '{8'hFF, 8'h01, 8'hFF, 8'h01};
  localparam logic [3:0] AND_T = 4'b1000;
  localparam logic [3:0] XOR_T = 4'b0110;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse start, confirm INIT cleared everything, then feed samples cyclically
  // until done. stall_at = index of the sample before which valid is held low.
  task automatic run_train(input bit use_b, input logic [3:0] tvec, input int stall_at, output int sent);
    int k = 0;
    int guard = 0;
    bit rdy, dn;
    sent = 0;
    @(negedge clk);
    if (use_b) b_start = 1'b1; else a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    b_start = 1'b0;
    @(negedge clk);
    chk("init_ready", use_b ? b_ready : a_ready, 1);
    chk("init_w0", use_b ? $signed(b_weights[15:0]) : $signed(a_weights[15:0]), 0);
    chk("init_w1", use_b ? $signed(b_weights[31:16]) : $signed(a_weights[31:16]), 0);
    chk("init_bias", use_b ? $signed(b_bias) : $signed(a_bias), 0);
    chk("init_epoch", use_b ? 32'(b_epoch) : 32'(a_epoch), 0);
    chk("init_conv", use_b ? b_conv : a_conv, 0);
    dn = 1'b0;
    while (guard < 2000) begin
      rdy = use_b ? b_ready : a_ready;
      dn  = use_b ? b_done : a_done;
      if (dn) break;
      if (rdy) begin
        if (sent == stall_at) begin
          // Sample 0 of AND caused one update: w=(1,1), bias=-1, err=1.
          for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("stall_ready", a_ready, 1);
          end
          chk("stall_w0", $signed(a_weights[15:0]), 1);
          chk("stall_w1", $signed(a_weights[31:16]), 1);
          chk("stall_bias", $signed(a_bias), -1);
          chk("stall_err", 32'(a_err), 1);
          chk("stall_epoch", 32'(a_epoch), 0);
          chk("stall_busy", a_busy, 1);
        end
        sample_valid = 1'b1;
        sample_x     = {tx1[k], tx0[k]};
        sample_t     = tvec[k];
        $display("%0t inst=%s sample=%0d x0=%0d x1=%0d t=%0d", $time, use_b ? "B" : "A", sent,
                 $signed(tx0[k]), $signed(tx1[k]), tvec[k]);
        @(negedge clk);
        sample_valid = 1'b0;
        sent++;
        k = (k + 1) % 4;
      end else begin
        @(negedge clk);
        guard++;
      end
    end
    chk("train_done_timeout", dn, 1);
  endtask

  task automatic check_and_final(input string tag, input int sent);
    $display("%0t %s result w0=%0d w1=%0d bias=%0d epoch=%0d err=%0d conv=%0d", $time, tag,
             $signed(a_weights[15:0]), $signed(a_weights[31:16]), $signed(a_bias), a_epoch, a_err, a_conv);
    chk({tag, "_sent"}, sent, 8);
    chk({tag, "_done"}, a_done, 1);
    chk({tag, "_busy"}, a_busy, 0);
    chk({tag, "_conv"}, a_conv, 1);
    chk({tag, "_epoch"}, 32'(a_epoch), 1);
    chk({tag, "_err"}, 32'(a_err), 0);
    chk({tag, "_w0"}, $signed(a_weights[15:0]), 1);
    chk({tag, "_w1"}, $signed(a_weights[31:16]), 1);
    chk({tag, "_bias"}, $signed(a_bias), -1);
  endtask

  initial begin
    int sent;
    int n;
    #3;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_a_weights", a_weights, 0);
    chk("rst_a_bias", $signed(a_bias), 0);
    chk("rst_b_weights", b_weights, 0);
    chk("rst_c_weights", $signed(c_weights), 0);
    chk("rst_c_flags", {c_ready, c_busy, c_done, c_conv}, 0);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    // AND with 20-cycle backpressure before sample 1.
    run_train(1'b0, AND_T, 1, sent);
    check_and_final("and1", sent);
    repeat (5) @(negedge clk);
    chk("done_hold_w0", $signed(a_weights[15:0]), 1);
    chk("done_hold_done", a_done, 1);

    // Restart from DONE: INIT clears, identical training repeats.
    run_train(1'b0, AND_T, -1, sent);
    check_and_final("and2", sent);

    // Reset while in UPDATE: accept sample 0 (misclassified), then 4 edges later
    // the first weight has been written and the bias step has not run yet.
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    n = 0;
    while (!a_ready && n < 10) begin @(negedge clk); n++; end
    chk("rstupd_ready", a_ready, 1);
    sample_valid = 1'b1; sample_x = {tx1[0], tx0[0]}; sample_t = 1'b0;
    $display("%0t inst=A sample=0 x0=-1 x1=-1 t=0 (reset during update)", $time);
    @(posedge clk); #1 sample_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("rstupd_busy", a_busy, 1);
    chk("rstupd_w0", $signed(a_weights[15:0]), 1);
    rst_a = 1'b0;
    #1;
    chk("rstupd_weights", a_weights, 0);
    chk("rstupd_bias", $signed(a_bias), 0);
    chk("rstupd_flags", {a_ready, a_busy, a_done, a_conv}, 0);
    chk("rstupd_cnts", {a_epoch, a_err}, 0);
    @(negedge clk); rst_a = 1'b1;
    run_train(1'b0, AND_T, -1, sent);
    check_and_final("and3", sent);

    // XOR never separates: every epoch returns to w=(0,0), bias=0 with 4 errors.
    run_train(1'b1, XOR_T, -1, sent);
    $display("%0t xor result w0=%0d w1=%0d bias=%0d epoch=%0d err=%0d conv=%0d", $time,
             $signed(b_weights[15:0]), $signed(b_weights[31:16]), $signed(b_bias), b_epoch, b_err, b_conv);
    chk("xor_sent", sent, 32);
    chk("xor_done", b_done, 1);
    chk("xor_conv", b_conv, 0);
    chk("xor_epoch", 32'(b_epoch), 7);
    chk("xor_err", 32'(b_err), 4);
    chk("xor_weights", b_weights, 0);
    chk("xor_bias", $signed(b_bias), 0);

    // Single weight: x=-128, t=-1 -> delta +128 on an 8-bit weight.
    @(negedge clk); c_start = 1'b1;
    @(negedge clk); c_start = 1'b0;
    n = 0;
    while (!c_ready && n < 10) begin @(negedge clk); n++; end
    chk("sat_ready", c_ready, 1);
    c_valid = 1'b1; c_x = 8'h80; c_t = 1'b0;
    $display("%0t inst=C sample=0 x0=-128 t=0", $time);
    @(negedge clk);
    c_valid = 1'b0;
    n = 1;
    while (!c_ready && n < 50) begin @(negedge clk); n++; end
    $display("%0t inst=C result w=%0d bias=%0d latency=%0d", $time, $signed(c_weights), $signed(c_bias), n);
    chk("sat_latency", n, 6);
`ifdef PERCEPTRON_SAT_EN
    chk("sat_w", $signed(c_weights), 127);
`else
    chk("sat_w", $signed(c_weights), -128);
`endif
    chk("sat_bias", $signed(c_bias), -1);
    chk("sat_epoch", 32'(c_epoch), 1);
    chk("sat_err", 32'(c_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
